// File: rtl/r408_dbus_arb.sv
// Two-master round-robin arbiter for the R408 8-bit data bus (master 0 = core LSU, master 1 = host/DMA).
// Latency: request seen in cycle N drives s_read/s_write from N+1; mi_rdy is combinational with s_rdy.
// Backpressure: masters hold requests until mi_rdy; optional abort via DBUS_ARB_TIMEOUT_EN.
module r408_dbus_arb #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_read,
  input  logic          m0_write,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rdy,
  output logic          m0_err,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_read,
  input  logic          m1_write,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rdy,
  output logic          m1_err,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_read,
  output logic          s_write,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rdy,
  output logic [1:0]    gnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY0 = 2'd1;
  localparam logic [1:0] ST_BUSY1 = 2'd2;

  // The abort counter is 8 bits wide, so the limit must fit in it.
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("r408_dbus_arb: TIMEOUT must be in 1..255");
  end

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;      // 0 = M0 last granted, 1 = M1
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;
  logic          s_read_q, s_read_d;
  logic          s_write_q, s_write_d;

  logic own0, own1, busy, abort;
  logic req0, req1, pick1, win_rd, win_wr;

  assign own0 = (state_q == ST_BUSY0);
  assign own1 = (state_q == ST_BUSY1);
  assign busy = own0 | own1;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // On a tie, the master that was not served last wins.
  assign pick1  = req1 & (~req0 | ~last_q);
  assign win_wr = pick1 ? m1_write : m0_write;
  assign win_rd = pick1 ? m1_read  : m0_read;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;

  // Abort fires in the BUSY cycle in which the counter would reach TIMEOUT; s_rdy wins a tie.
  assign abort = busy & ~s_rdy & (cnt_q == TO_LAST);

  // Count BUSY cycles spent waiting on the slave; restart at every grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE)
      cnt_d = 8'd0;
    else if (!s_rdy)
      cnt_d = cnt_q + 8'd1;
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  // Arbitration and slave-request next state.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_read_d  = s_read_q;
    s_write_d = s_write_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          state_d   = pick1 ? ST_BUSY1 : ST_BUSY0;
          last_d    = pick1;
          s_addr_d  = pick1 ? m1_addr  : m0_addr;
          s_wdata_d = pick1 ? m1_wdata : m0_wdata;
          // Read+write together is treated as a write.
          s_write_d = win_wr;
          s_read_d  = win_rd & ~win_wr;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (s_rdy | abort) begin
          state_d   = ST_IDLE;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        s_read_d  = 1'b0;
        s_write_d = 1'b0;
      end
    endcase
  end

  // State and slave-side request registers; reset drops strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_read_q  <= 1'b0;
      s_write_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_read_q  <= s_read_d;
      s_write_q <= s_write_d;
    end
  end

  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_read  = s_read_q;
  assign s_write = s_write_q;
  assign gnt     = {own1, own0};

  // Completion return: only the owner sees rdy/data; aborts return all-ones data.
  assign m0_rdy   = own0 & (s_rdy | abort);
  assign m1_rdy   = own1 & (s_rdy | abort);
  assign m0_err   = own0 & abort;
  assign m1_err   = own1 & abort;
  assign m0_rdata = !own0 ? '0 : (s_rdy ? s_rdata : (abort ? '1 : '0));
  assign m1_rdata = !own1 ? '0 : (s_rdy ? s_rdata : (abort ? '1 : '0));

endmodule

// File: tb/tb_r408_dbus_arb.sv
// Bench for r408_dbus_arb: directed scenarios plus randomized traffic against a transaction model.
// Inputs are driven 1 time unit after the rising edge, outputs are checked 2 units after it.
// Timeout scenario is compiled in only with DBUS_ARB_TIMEOUT_EN (limit 4).
module tb_r408_dbus_arb;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int TO_P = 4;
`else
  localparam int TO_P = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] m0_addr = '0, m1_addr = '0, s_addr;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0, s_wdata;
  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        m0_rdy, m1_rdy, m0_err, m1_err;
  logic        s_read, s_write;
  logic [7:0]  s_rdata = '0;
  logic        s_rdy = 1'b0;
  logic [1:0]  gnt;

  int n_cmp = 0;
  int n_fail = 0;

  r408_dbus_arb #(.AW(16), .DW(8), .TIMEOUT(TO_P)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
    .m0_rdata(m0_rdata), .m0_rdy(m0_rdy), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
    .m1_rdata(m1_rdata), .m1_rdy(m1_rdy), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_read(s_read), .s_write(s_write),
    .s_rdata(s_rdata), .s_rdy(s_rdy), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; s_rdy = 0; s_rdata = '0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    s_rdy = 1'b1; s_rdata = 8'h5A;   // s_rdy while idle must be ignored
    #1;
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", gnt); end
    n_cmp++; if ({s_read, s_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {s_read, s_write}); end
    n_cmp++; if (s_addr !== 16'h0 || s_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_sbus got %h/%h want 0000/00", s_addr, s_wdata); end
    n_cmp++; if ({m0_rdy, m1_rdy, m0_err, m1_err} !== 4'b0) begin n_fail++; $display("FAIL idle_rdy got %b want 0000", {m0_rdy, m1_rdy, m0_err, m1_err}); end
    n_cmp++; if (m0_rdata !== 8'h0 || m1_rdata !== 8'h0) begin n_fail++; $display("FAIL idle_rdata got %h/%h want 00/00", m0_rdata, m1_rdata); end
    s_rdy = 1'b0;
  endtask

  task automatic test_m0_read();
    do_reset();
    m0_addr = 16'h1234; m0_read = 1'b1;
    cyc();
    n_cmp++; if (s_read !== 1'b1 || s_write !== 1'b0) begin n_fail++; $display("FAIL m0rd_strobe got r%b w%b want r1 w0", s_read, s_write); end
    n_cmp++; if (s_addr !== 16'h1234) begin n_fail++; $display("FAIL m0rd_addr got %h want 1234", s_addr); end
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL m0rd_gnt got %b want 01", gnt); end
    cyc();
    n_cmp++; if (m0_rdy !== 1'b0 || m0_rdata !== 8'h0) begin n_fail++; $display("FAIL m0rd_wait got rdy%b %h want rdy0 00", m0_rdy, m0_rdata); end
    cyc();
    s_rdy = 1'b1; s_rdata = 8'hA5;
    #1;
    n_cmp++; if (m0_rdy !== 1'b1 || m0_rdata !== 8'hA5) begin n_fail++; $display("FAIL m0rd_done got rdy%b %h want rdy1 a5", m0_rdy, m0_rdata); end
    n_cmp++; if (m1_rdy !== 1'b0) begin n_fail++; $display("FAIL m0rd_m1rdy got %b want 0", m1_rdy); end
    m0_read = 1'b0;
    cyc();
    s_rdy = 1'b0;
    #1;
    n_cmp++; if (gnt !== 2'b00 || s_read !== 1'b0 || m0_rdy !== 1'b0) begin n_fail++; $display("FAIL m0rd_idle got gnt%b r%b rdy%b want 00 0 0", gnt, s_read, m0_rdy); end
  endtask

  task automatic test_alternate();
    logic [1:0] want;
    do_reset();
    m0_addr = 16'h0100; m0_wdata = 8'h11; m0_write = 1'b1;
    m1_addr = 16'h0200; m1_wdata = 8'h22; m1_write = 1'b1;
    for (int t = 0; t < 4; t++) begin
      want = (t % 2 == 0) ? 2'b01 : 2'b10;
      cyc();
      n_cmp++; if (gnt !== want) begin n_fail++; $display("FAIL alt_gnt[%0d] got %b want %b", t, gnt, want); end
      n_cmp++; if (s_addr !== ((t % 2 == 0) ? 16'h0100 : 16'h0200)) begin n_fail++; $display("FAIL alt_addr[%0d] got %h", t, s_addr); end
      s_rdy = 1'b1;
      #1;
      n_cmp++; if ({m1_rdy, m0_rdy} !== want) begin n_fail++; $display("FAIL alt_rdy[%0d] got %b want %b", t, {m1_rdy, m0_rdy}, want); end
      cyc();
      s_rdy = 1'b0;
      #1;
      n_cmp++; if (gnt !== 2'b00 || s_write !== 1'b0) begin n_fail++; $display("FAIL alt_idle[%0d] got gnt%b w%b want 00 0", t, gnt, s_write); end
    end
    m0_write = 1'b0; m1_write = 1'b0;
    cyc();
  endtask

  task automatic test_same_cycle_rdy();
    do_reset();
    m1_addr = 16'hBEEF; m1_wdata = 8'h3C; m1_write = 1'b1;
    cyc();
    s_rdy = 1'b1; s_rdata = 8'h77;
    #1;
    n_cmp++; if (s_write !== 1'b1 || s_addr !== 16'hBEEF || s_wdata !== 8'h3C) begin n_fail++; $display("FAIL m1wr_sbus got w%b %h/%h want w1 beef/3c", s_write, s_addr, s_wdata); end
    n_cmp++; if (m1_rdy !== 1'b1 || m0_rdy !== 1'b0 || gnt !== 2'b10) begin n_fail++; $display("FAIL m1wr_rdy got m1%b m0%b gnt%b want 1 0 10", m1_rdy, m0_rdy, gnt); end
    m1_write = 1'b0;
    cyc();
    s_rdy = 1'b0;
    #1;
    n_cmp++; if (gnt !== 2'b00 || s_write !== 1'b0) begin n_fail++; $display("FAIL m1wr_idle got gnt%b w%b want 00 0", gnt, s_write); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_addr = 16'h4000; m1_wdata = 8'h99; m1_write = 1'b1;
    cyc();
    n_cmp++; if (gnt !== 2'b10 || s_write !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got gnt%b w%b want 10 1", gnt, s_write); end
    #2;
    rst = 1'b1;
    s_rdy = 1'b1;
    #1;
    n_cmp++; if (s_write !== 1'b0 || gnt !== 2'b00) begin n_fail++; $display("FAIL rstmid_async got w%b gnt%b want 0 00", s_write, gnt); end
    m1_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_cmp++; if (m1_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_rdy[%0d] got %b want 0", k, m1_rdy); end
    end
    rst = 1'b0;
    s_rdy = 1'b0;
    cyc();
  endtask

  task automatic test_rw_both();
    do_reset();
    m0_addr = 16'h00F0; m0_wdata = 8'hC3; m0_read = 1'b1; m0_write = 1'b1;
    cyc();
    n_cmp++; if (s_write !== 1'b1 || s_read !== 1'b0 || s_wdata !== 8'hC3) begin n_fail++; $display("FAIL rw_both got w%b r%b %h want w1 r0 c3", s_write, s_read, s_wdata); end
    s_rdy = 1'b1;
    #1;
    m0_read = 1'b0; m0_write = 1'b0;
    cyc();
    s_rdy = 1'b0;
  endtask

`ifdef DBUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_addr = 16'h0ABC; m0_read = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      n_cmp++; if (m0_rdy !== 1'b0 || m0_err !== 1'b0) begin n_fail++; $display("FAIL to_early[%0d] got rdy%b err%b want 0 0", c, m0_rdy, m0_err); end
    end
    cyc();
    n_cmp++; if (m0_rdy !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 8'hFF) begin n_fail++; $display("FAIL to_abort got rdy%b err%b %h want 1 1 ff", m0_rdy, m0_err, m0_rdata); end
    m0_read = 1'b0;
    cyc();
    n_cmp++; if (gnt !== 2'b00 || s_read !== 1'b0) begin n_fail++; $display("FAIL to_idle got gnt%b r%b want 00 0", gnt, s_read); end
  endtask
`endif

  // Randomized traffic: model keeps one pending request per master and applies the
  // arbitration rules (sole requester wins; on a tie the master not served last wins).
  task automatic test_random();
    logic        pend [2];
    logic [15:0] a    [2];
    logic [7:0]  wd   [2];
    logic        rd   [2];
    logic        wr   [2];
    int          lastw, w, d, op;
    logic [7:0]  sd;
    logic [1:0]  want;
    do_reset();
    lastw = 1;
    pend[0] = 0; pend[1] = 0;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && (($urandom_range(0, 2) != 0) || (i == 1 && !pend[0]))) begin
          pend[i] = 1'b1;
          a[i] = 16'($urandom); wd[i] = 8'($urandom);
          op = $urandom_range(0, 2);
          rd[i] = (op != 1); wr[i] = (op != 0);
        end
      end
      m0_addr = a[0]; m0_wdata = wd[0]; m0_read = pend[0] & rd[0]; m0_write = pend[0] & wr[0];
      m1_addr = a[1]; m1_wdata = wd[1]; m1_read = pend[1] & rd[1]; m1_write = pend[1] & wr[1];
      w = (pend[0] && pend[1]) ? (lastw == 1 ? 0 : 1) : (pend[0] ? 0 : 1);
      want = (w == 1) ? 2'b10 : 2'b01;
      cyc();
      n_cmp++; if (gnt !== want) begin n_fail++; $display("FAIL rnd_gnt[%0d] got %b want %b", t, gnt, want); end
      n_cmp++; if (s_addr !== a[w] || s_wdata !== wd[w]) begin n_fail++; $display("FAIL rnd_sbus[%0d] got %h/%h want %h/%h", t, s_addr, s_wdata, a[w], wd[w]); end
      n_cmp++; if (s_write !== wr[w] || s_read !== (rd[w] & ~wr[w])) begin n_fail++; $display("FAIL rnd_op[%0d] got w%b r%b want w%b r%b", t, s_write, s_read, wr[w], rd[w] & ~wr[w]); end
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        s_rdy = 1'b0; s_rdata = 8'($urandom);
        #1;
        n_cmp++; if ({m1_rdy, m0_rdy} !== 2'b00 || m0_rdata !== 8'h0 || m1_rdata !== 8'h0) begin n_fail++; $display("FAIL rnd_wait[%0d] got rdy%b %h/%h want 00 00/00", t, {m1_rdy, m0_rdy}, m0_rdata, m1_rdata); end
        cyc();
      end
      sd = 8'($urandom);
      s_rdy = 1'b1; s_rdata = sd;
      #1;
      n_cmp++; if ({m1_rdy, m0_rdy} !== want || {m1_err, m0_err} !== 2'b00) begin n_fail++; $display("FAIL rnd_rdy[%0d] got rdy%b err%b want rdy%b err00", t, {m1_rdy, m0_rdy}, {m1_err, m0_err}, want); end
      n_cmp++; if ((w == 0 ? m0_rdata : m1_rdata) !== sd || (w == 0 ? m1_rdata : m0_rdata) !== 8'h0) begin n_fail++; $display("FAIL rnd_rdata[%0d] got m0 %h m1 %h want owner %h other 00", t, m0_rdata, m1_rdata, sd); end
      pend[w] = 1'b0;
      lastw = w;
      if (w == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
      else        begin m1_read = 1'b0; m1_write = 1'b0; end
      cyc();
      s_rdy = 1'b0;
      #1;
      n_cmp++; if (gnt !== 2'b00 || {s_read, s_write} !== 2'b00) begin n_fail++; $display("FAIL rnd_idle[%0d] got gnt%b rw%b want 00 00", t, gnt, {s_read, s_write}); end
    end
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_alternate();
    test_same_cycle_rdy();
    test_reset_mid();
    test_rw_both();
`ifdef DBUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
